register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 51 +++++
 tb/tb_register_file.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x 32-bit register file with x0 hardwired to zero, two asynchronous read
// ports, and either a single write (we=1) or a dual load (we=0) per edge.
module register_file (
  output logic [31:0] reg_rs1,
  output logic [31:0] reg_rs2,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] din,
  input  logic        clock,
  input  logic        we,
  input  logic        reset_n
);

  logic [31:0] x_view [32];

  assign x_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      logic [31:0] x_q;
      logic [31:0] x_d;

      // Both polarity tests are explicit so an unknown we updates nothing.
      // The rs2 load is applied last so it wins when rs1 == rs2.
      always_comb begin
        x_d = x_q;
        if (we) begin
          if (rd == 5'(gi)) x_d = din;
        end else if (!we) begin
          if (rs1 == 5'(gi)) x_d = rs1_data;
          if (rs2 == 5'(gi)) x_d = rs2_data;
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) x_q <= '0;
        else          x_q <= x_d;
      end

      assign x_view[gi] = x_q;
    end
  endgenerate

  assign reg_rs1 = x_view[rs1];
  assign reg_rs2 = x_view[rs2];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, reset corner
// sequence, then randomized traffic against an array reference model.
module tb_register_file;

  logic [31:0] reg_rs1, reg_rs2;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data, din;
  logic        clock, we, reset_n;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [32];

  register_file dut (
    .reg_rs1(reg_rs1), .reg_rs2(reg_rs2), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .din(din),
    .clock(clock), .we(we), .reset_n(reset_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, din;
    logic [31:0] pre1, pre2, post1, post2;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference behaviour: one write, or two loads with rs2 applied last; x0 never changes.
  task automatic model_edge(input logic w, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [4:0] ad, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] vd);
    if (w) begin
      if (ad != 0) model[ad] = vd;
    end else begin
      if (a1 != 0) model[a1] = v1;
      if (a2 != 0) model[a2] = v2;
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] ad, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] vd);
    we = w; rs1 = a1; rs2 = a2; rd = ad; rs1_data = v1; rs2_data = v2; din = vd;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;

    vecs[0] = '{"x0_write_ignored", 1'b1, 5'd5, 5'd31, 5'd0, 32'h1, 32'h2, 32'hFFFF_FFFF,
                32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{"load_rs1_zero",    1'b0, 5'd0, 5'd1,  5'd9, 32'h5, 32'h6, 32'h55,
                32'h0, 32'h0, 32'h0, 32'h6};
    vecs[2] = '{"dual_load",        1'b0, 5'd3, 5'd1,  5'd2, 32'h7, 32'h8, 32'h2,
                32'h0, 32'h6, 32'h7, 32'h8};
    vecs[3] = '{"write_no_bypass",  1'b1, 5'd2, 5'd1,  5'd2, 32'h4, 32'h0, 32'h2,
                32'h0, 32'h8, 32'h2, 32'h8};
    vecs[4] = '{"same_addr_rs2_win",1'b0, 5'd5, 5'd5,  5'd0, 32'hA, 32'hB, 32'h0,
                32'h0, 32'h0, 32'hB, 32'hB};
    vecs[5] = '{"load_rs2_zero",    1'b0, 5'd7, 5'd0,  5'd7, 32'h77, 32'h99, 32'h1234,
                32'h0, 32'h0, 32'h77, 32'h0};
    vecs[6] = '{"write_x31",        1'b1, 5'd31, 5'd3, 5'd31, 32'h0, 32'h0, 32'hDEAD_BEEF,
                32'h0, 32'h7, 32'hDEAD_BEEF, 32'h7};

    reset_n = 1'b0;
    drive(1'b1, 5'd5, 5'd31, 5'd0, '0, '0, '0);
    #2;
    check("reset_rs1", reg_rs1, 32'h0);
    check("reset_rs2", reg_rs2, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      drive(vecs[i].we, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].d1, vecs[i].d2, vecs[i].din);
      #1;
      check({vecs[i].name, "_pre1"}, reg_rs1, vecs[i].pre1);
      check({vecs[i].name, "_pre2"}, reg_rs2, vecs[i].pre2);
      @(posedge clock);
      model_edge(vecs[i].we, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].d1, vecs[i].d2, vecs[i].din);
      #1;
      check({vecs[i].name, "_post1"}, reg_rs1, vecs[i].post1);
      check({vecs[i].name, "_post2"}, reg_rs2, vecs[i].post2);
    end

    // x2 must have kept the value written in write_no_bypass; rd/din ignored during loads.
    @(negedge clock);
    drive(1'b1, 5'd2, 5'd5, 5'd0, '0, '0, '0);
    #1;
    check("x2_after_loads", reg_rs1, 32'h2);
    check("x5_readback", reg_rs2, 32'hB);

    // Asynchronous reset mid-cycle, held across an edge with a pending write.
    @(negedge clock);
    drive(1'b1, 5'd3, 5'd31, 5'd3, '0, '0, 32'h7);
    @(posedge clock);
    #1;
    check("x3_loaded", reg_rs1, 32'h7);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_async_rs1", reg_rs1, 32'h0);
    check("reset_async_rs2", reg_rs2, 32'h0);
    din = 32'h9;
    @(posedge clock);
    #1;
    check("reset_blocks_write", reg_rs1, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1;
    check("release_no_update", reg_rs1, 32'h0);
    @(posedge clock);
    model_edge(1'b1, 5'd3, 5'd31, 5'd3, '0, '0, 32'h9);
    #1;
    check("first_edge_after_reset", reg_rs1, 32'h9);

    // Randomized traffic; addresses are also re-pointed between edges to exercise async reads.
    for (int n = 0; n < 400; n++) begin
      logic        w;
      logic [4:0]  a1, a2, ad;
      logic [31:0] v1, v2, vd;
      @(negedge clock);
      w  = 1'($urandom_range(0, 1));
      a1 = 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      ad = 5'($urandom_range(0, 31));
      v1 = $urandom; v2 = $urandom; vd = $urandom;
      drive(w, a1, a2, ad, v1, v2, vd);
      #1;
      check("rand_pre1", reg_rs1, model[a1]);
      check("rand_pre2", reg_rs2, model[a2]);
      @(posedge clock);
      model_edge(w, a1, a2, ad, v1, v2, vd);
      #1;
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      #1;
      check("rand_post1", reg_rs1, model[rs1]);
      check("rand_post2", reg_rs2, model[rs2]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
